bcd_timer_ctrl: RTL
===================

# bcd_timer_ctrl

Sequencing controller for a chain of BCD decade counters. It loads a multi-digit BCD preset and counts it down to zero at a prescaled rate, then signals completion. Start, pause, resume and clear are driven by a small state machine. Used wherever the design needs a human-readable countdown: display timers and timeouts feeding 7-segment drivers.

## Interface
- `DIGITS`, 4: number of BCD decades; count width is 4*DIGITS.
- `PRESCALE`, 10: clk cycles per count step; minimum 1.
- `clk`, in, 1: single clock; all logic updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `clear`, in, 1: forces count to zero and state to IDLE.
- `load`, in, 1: captures `load_val` into count.
- `load_val`, in, 4*DIGITS: BCD preset, digit 0 in bits [3:0].
- `start`, in, 1: begins or resumes counting.
- `pause`, in, 1: suspends counting.
- `count`, out, 4*DIGITS: current BCD value, registered.
- `busy`, out, 1: high in RUN and PAUSE.
- `done`, out, 1: one-cycle pulse on reaching zero.
- `state`, out, 2: FSM state code, for debug.

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Reset (`rst_n` low at a clk edge): count=0, state=IDLE, busy=0, done=0, prescaler=0.
- Input priority per cycle: `clear` > `load` > `start` > `pause`.
- `clear`: count=0, state=IDLE, prescaler=0. Accepted in any state.
- `load`: count=`load_val`, prescaler=0. Accepted in any state. The state is kept, except that DONE goes to IDLE.
  - Any `load_val` digit above 9 is stored as 9.
- `start`:
  - From IDLE or DONE with count≠0: go to RUN, prescaler=0.
  - From PAUSE: go to RUN, prescaler keeps its held value.
  - With count=0: go to DONE and pulse `done`.
  - In RUN: ignored.
- `pause` in RUN: go to PAUSE; prescaler and count hold. Ignored in other states.
- Prescaler runs only in RUN.
  - Counts 0..PRESCALE-1.
  - A tick is issued on the cycle it equals PRESCALE-1, then it wraps to 0.
- On each tick, count decrements by one in BCD. Each digit borrows from the next one up; a digit at 0 wraps to 9.
  - Example: 0100 becomes 0099.
- When the decrement makes count 0: state goes to DONE and `done` is high for exactly the next cycle.
- DONE holds count=0 until `load`, `clear` or `start`.
- `busy` = (state==RUN or state==PAUSE), registered alongside state.

## Timing
- Latency from an input sampled at edge N to the outputs updated at edge N is 0 cycles. There is no combinational path from input to output.
- First decrement after `start` from IDLE lands on the PRESCALE-th edge after the start edge.
- Total run from preset V (as an integer) takes V*PRESCALE cycles from start to DONE, with no pauses.
- Pausing adds exactly the number of cycles spent in PAUSE.
- `load` on the same cycle as a tick: the load wins and the tick is discarded.
- `pause` on the same cycle as a tick: the decrement is applied, then state goes to PAUSE.
- `rst_n` low mid-run takes effect at the next edge with the reset values above. No partial decrement survives.

## Configuration
- `BCD_TIMER_AUTORELOAD_EN` defined:
  - An internal reload register captures each accepted `load_val`.
  - When count reaches zero in RUN, `done` still pulses. Count is reloaded from the register on the same edge, the state stays in RUN, and the prescaler restarts at 0.
  - If the reload value is 0, the block enters DONE instead.
  - `clear` also clears the reload register.
- Undefined: no reload register; behaviour as in Operation.

## Structure
- Shared package `bcd_pkg`:
  - State encoding typedef (IDLE/RUN/PAUSE/DONE).
  - `BCD_MAX` = 4'd9.
  - `BCD_W` = 4.
- Sub-module `bcd_digit_dec`, instantiated DIGITS times:
  - Inputs: a 4-bit digit, borrow-in, clamp-on-load.
  - Outputs: the next digit and borrow-out.
  - Borrow-in of digit 0 is the tick.
- The top level holds the FSM, prescaler, and the count and reload registers.

## Test plan
- All tests use DIGITS=4 and PRESCALE=1 unless stated otherwise.
- Reset: drive `rst_n` low during RUN with count=0042. Next edge: count=0000, state=IDLE, busy=0, done=0.
- Borrow chain: load 1000 then start. Sequence is 0999, 0998, …; after 1000 edges count=0000 and `done` pulses once; state=DONE.
- Pause/resume with PRESCALE=4: load 0003, start, pause for 7 cycles, then start. DONE is reached at exactly 12+7+pause/start overhead cycles, and count holds steady during the pause.
- Clamp and priority: load `load_val`=0xA1F5 → count reads 9195. Assert `load`+`clear` together → count=0000, state=IDLE.
- Zero start: start with count=0000 → state=DONE next edge and `done` high for 1 cycle. No RUN cycle occurs.
- `BCD_TIMER_AUTORELOAD_EN`: load 0002, start. `done` pulses every 2 cycles and count alternates 0001, 0002, 0001, … while state stays in RUN.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD countdown timer slice.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Control/status bundle of bcd_timer_ctrl; master drives commands, slave is the timer.
interface bcd_timer_ctrl_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);

  logic                      clear;
  logic                      load;
  logic [BCD_W*DIGITS-1:0]   load_val;
  logic                      start;
  logic                      pause;
  logic [BCD_W*DIGITS-1:0]   count;
  logic                      busy;
  logic                      done;
  state_t                    state;

  modport master (
    output clear, load, load_val, start, pause,
    input  count, busy, done, state
  );

  modport slave (
    input  clear, load, load_val, start, pause,
    output count, busy, done, state
  );

endinterface

// File: rtl/bcd_digit_dec.sv
// One BCD decade: clamps a loaded digit to 9, or decrements with borrow propagation.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             borrow_in,
  input  logic             clamp,
  output logic [BCD_W-1:0] digit_nx,
  output logic             borrow_out
);

  always_comb begin
    digit_nx   = digit;
    borrow_out = 1'b0;
    if (clamp) begin
      digit_nx = (digit > BCD_MAX) ? BCD_MAX : digit;
    end else if (borrow_in) begin
      borrow_out = (digit == '0);
      digit_nx   = borrow_out ? BCD_MAX : digit - BCD_W'(1);
    end
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// BCD countdown controller: FSM, prescaler and count register over a digit chain.
// Optional auto-reload when BCD_TIMER_AUTORELOAD_EN is defined.
module bcd_timer_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 10
)(
  input  logic             clk,
  input  logic             rst_n,
  bcd_timer_ctrl_if.slave  bus
);

  localparam int unsigned   CW    = BCD_W * DIGITS;
  localparam int unsigned   PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [CW-1:0]   count_q;
  logic [CW-1:0]   dec_in;
  logic [CW-1:0]   dec_out;
  logic [DIGITS:0] borrow;
  logic [PW-1:0]   presc_q;
  state_t          state_q;
  logic            busy_q;
  logic            done_q;
  logic            tick;
  logic            dec_zero;
`ifdef BCD_TIMER_AUTORELOAD_EN
  logic [CW-1:0]   reload_q;
`endif

  assign tick      = (state_q == RUN) && (presc_q == PLAST);
  // The chain doubles as the load clamp: with load high every digit clamps and no borrow ripples.
  assign dec_in    = bus.load ? bus.load_val : count_q;
  assign borrow[0] = tick;
  assign dec_zero  = (dec_out == '0) && !borrow[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_dec u_dig (
      .digit      (dec_in[g*BCD_W +: BCD_W]),
      .borrow_in  (borrow[g]),
      .clamp      (bus.load),
      .digit_nx   (dec_out[g*BCD_W +: BCD_W]),
      .borrow_out (borrow[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      presc_q  <= '0;
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.clear) begin
        count_q  <= '0;
        presc_q  <= '0;
        state_q  <= IDLE;
        busy_q   <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
        reload_q <= '0;
`endif
      end else if (bus.load) begin
        count_q <= dec_out;
        presc_q <= '0;
        if (state_q == DONE) state_q <= IDLE;
`ifdef BCD_TIMER_AUTORELOAD_EN
        reload_q <= dec_out;
`endif
      end else if (bus.start && state_q != RUN) begin
        if (count_q == '0) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          if (state_q != PAUSE) presc_q <= '0;
        end
      end else if (state_q == RUN) begin
        if (tick) begin
          presc_q <= '0;
          if (dec_zero) begin
            done_q <= 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
            if (reload_q != '0) begin
              count_q <= reload_q;
            end else begin
              count_q <= '0;
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
`else
            count_q <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
`endif
          end else begin
            count_q <= dec_out;
            if (bus.pause) state_q <= PAUSE;
          end
        end else if (bus.pause) begin
          state_q <= PAUSE;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule
